hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Parametrised hazard and bypass controller for the 5-stage MIPS pipeline.
- Tracks destination registers of in-flight instructions in a DEPTH-entry shift scoreboard covering X, M and W.
- Generates the operand-bypass selects for the instruction entering X, a load-use stall for fetch/decode, and bubble insertion on branch flush.
- Replaces the single rs-vs-rd MX compare with full MX/WX bypassing on both rs and rt, including load-latency handling.

Parameters:
- REG_AW, 5: register-specifier width.
- DEPTH, 3: scoreboard entries after decode (0=X, 1=M, DEPTH-1=W); legal range 2..8.
- LOAD_STAGE, 2: entry index at which load data first becomes bypassable; legal range 1..DEPTH-1.
- SELW, derived as $clog2(DEPTH) (min 1): width of bypass selects; localparam, not overridable.

Ports:
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  REG_AW  decode rs field
- id_rt  in  REG_AW  decode rt field
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_dst  in  REG_AW  destination (rt or rd, already muxed)
- id_wen  in  1  instruction writes regfile
- id_is_load  in  1  instruction is a load
- flush  in  1  branch/jump taken in X; kill decode instruction
- stall  out  1  hold PC and F/D, inject bubble into X (combinational)
- x_fwd_rs_sel  out  SELW  rs source for insn now in X: 0=regfile/D-X latch, k=entry k
- x_fwd_rt_sel  out  SELW  same for rt
- x_valid  out  1  entry 0 holds a real instruction

Behaviour:
- Entry fields: valid, dst, wen, is_load.
- Match at entry k: entry valid && wen && dst==src && src!=0 && uses_src.
- Match result: youngest (lowest k) match wins.
- Bypass select: match at entry k gives sel = k+1. Matches at k=DEPTH-1 give sel=0; the regfile is write-before-read, so a retiring value is already visible.
- Load-use stall: stall=1 when id_valid && !flush and some youngest match at entry k is a load with k+1 < LOAD_STAGE.
- Stall evaluation: independent for rs and rt, ORed. Re-evaluated every cycle, so the stall deasserts on its own once the producer advances.
- Default stall timing: exactly 1 cycle for a load immediately followed by its consumer; 0 cycles with one independent instruction between.
- Each rising edge, not reset: entry[k] <= entry[k-1] for k>=1. Older entries always advance and are never frozen by stall.
- Entry 0 <= decode insn, with selects registered to x_fwd_*_sel, when id_valid && !stall && !flush.
- Otherwise entry 0 <= bubble: valid=0, wen=0, is_load=0, dst=0, and selects <= 0.
- flush && stall same cycle: flush wins. stall forced 0, decode insn dropped, bubble inserted.
- flush never clears entries 1..DEPTH-1, since older instructions commit.
- r0 destination never creates a hazard or bypass.
- Reset, takes priority over all inputs: all entries invalid, x_valid=0, x_fwd_rs_sel=0, x_fwd_rt_sel=0. stall reads 0 the same cycle.
- Reset mid-stall: stall drops the cycle reset is sampled; state is fully bubbles next cycle.
- Latency: selects valid 1 cycle after the consumer's decode cycle, aligned with the D/X register.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With it defined, add three 32-bit outputs:
  - stall_count: cycles with stall=1.
  - flush_count: cycles with flush=1 && id_valid.
  - bypass_count: instructions entering X with any nonzero select.
- Counters clear on reset and wrap modulo 2^32.
- Without it, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 back-to-back -> sub enters X with x_fwd_rs_sel=1, stall never asserts.
- add r3 then nop then or r6,r0,r3 (rt) -> or enters X with x_fwd_rt_sel=2, x_fwd_rs_sel=0.
- lw r7,0(r29) then add r8,r7,r7 -> stall=1 for exactly one cycle, x_valid=0 for that bubble, then add in X with both sels=2.
- lw r7 and dependent add in decode while flush=1 -> stall=0, x_valid=0 next cycle; lw still advances to M.
- addi r0,r1,5 then add r2,r0,r0 -> no stall, both sels=0; same with reset pulsed mid-stall -> x_valid=0, sels=0, stall=0.
- HAZARD_STATS_EN, DEPTH=4, LOAD_STAGE=3: lw r9 then consumer -> stall 2 cycles, stall_count=2, bypass_count=1 (sel=3).

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard and bypass controller for the 5-stage pipeline: shift scoreboard over X..W,
// MX/WX bypass selects for rs/rt, load-use stall and flush bubbles. Optional HAZARD_STATS_EN counters.
module hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SELW      = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wen,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SELW-1:0]   x_fwd_rs_sel,
    output logic [SELW-1:0]   x_fwd_rt_sel,
    output logic              x_valid
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
    output logic [31:0]       bypass_count
`endif
);

    logic [DEPTH-1:0]             ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]             ent_wen_q, ent_wen_d;
    logic [DEPTH-1:0]             ent_load_q, ent_load_d;
    logic [DEPTH-1:0][REG_AW-1:0] ent_dst_q, ent_dst_d;
    logic [SELW-1:0]              rs_sel_q, rs_sel_d;
    logic [SELW-1:0]              rt_sel_q, rt_sel_d;
    logic [SELW:0]                rs_hit, rt_hit;
    logic                         accept;

    // Returns {load_use_stall, bypass_sel}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [SELW:0] lookup(
        input logic [REG_AW-1:0]             src,
        input logic                          uses,
        input logic [DEPTH-1:0]              vld,
        input logic [DEPTH-1:0]              wen,
        input logic [DEPTH-1:0]              ld,
        input logic [DEPTH-1:0][REG_AW-1:0]  dst
    );
        logic [SELW:0] r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (uses && (src != '0) && vld[k] && wen[k] && (dst[k] == src)) begin
                // A retiring producer is already visible through the write-before-read regfile.
                r[SELW-1:0] = (k == DEPTH - 1) ? '0 : SELW'(k + 1);
                r[SELW]     = ld[k] && ((k + 1) < LOAD_STAGE);
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_hit = lookup(id_rs, id_uses_rs, ent_valid_q, ent_wen_q, ent_load_q, ent_dst_q);
        rt_hit = lookup(id_rt, id_uses_rt, ent_valid_q, ent_wen_q, ent_load_q, ent_dst_q);
        stall  = !reset && id_valid && !flush && (rs_hit[SELW] || rt_hit[SELW]);
        accept = id_valid && !stall && !flush;

        ent_valid_d = {ent_valid_q[DEPTH-2:0], accept};
        ent_wen_d   = {ent_wen_q[DEPTH-2:0], accept && id_wen};
        ent_load_d  = {ent_load_q[DEPTH-2:0], accept && id_is_load};
        ent_dst_d   = '0;
        ent_dst_d[0] = accept ? id_dst : '0;
        for (int k = 1; k < DEPTH; k++) begin
            ent_dst_d[k] = ent_dst_q[k-1];
        end
        rs_sel_d = accept ? rs_hit[SELW-1:0] : '0;
        rt_sel_d = accept ? rt_hit[SELW-1:0] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid_q <= '0;
            ent_wen_q   <= '0;
            ent_load_q  <= '0;
            ent_dst_q   <= '0;
            rs_sel_q    <= '0;
            rt_sel_q    <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_wen_q   <= ent_wen_d;
            ent_load_q  <= ent_load_d;
            ent_dst_q   <= ent_dst_d;
            rs_sel_q    <= rs_sel_d;
            rt_sel_q    <= rt_sel_d;
        end
    end

    assign x_valid      = ent_valid_q[0];
    assign x_fwd_rs_sel = rs_sel_q;
    assign x_fwd_rt_sel = rt_sel_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] bypass_count_q, bypass_count_d;

    always_comb begin
        stall_count_d  = stall_count_q + 32'(stall);
        flush_count_d  = flush_count_q + 32'(flush && id_valid);
        bypass_count_d = bypass_count_q + 32'((rs_sel_d != '0) || (rt_sel_d != '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q  <= '0;
            flush_count_q  <= '0;
            bypass_count_q <= '0;
        end else begin
            stall_count_q  <= stall_count_d;
            flush_count_q  <= flush_count_d;
            bypass_count_q <= bypass_count_d;
        end
    end

    assign stall_count  = stall_count_q;
    assign flush_count  = flush_count_q;
    assign bypass_count = bypass_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit: default instance (DEPTH=3, LOAD_STAGE=2)
// plus a DEPTH=4, LOAD_STAGE=3 instance sharing the same decode inputs.
module tb_hazard_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_wen, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_dst;

    logic       stall_a, stall_b, xv_a, xv_b;
    logic [1:0] rs_sel_a, rt_sel_a, rs_sel_b, rt_sel_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] stc_a, flc_a, byc_a, stc_b, flc_b, byc_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       xv;
        logic [1:0] rs;
        logic [1:0] rt;
    } xexp_t;
    xexp_t sb_q[$];

    always #5 clock = ~clock;

    hazard_unit u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_a),
        .x_fwd_rs_sel(rs_sel_a), .x_fwd_rt_sel(rt_sel_a), .x_valid(xv_a)
`ifdef HAZARD_STATS_EN
        , .stall_count(stc_a), .flush_count(flc_a), .bypass_count(byc_a)
`endif
    );

    hazard_unit #(.DEPTH(4), .LOAD_STAGE(3)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .flush(flush), .stall(stall_b),
        .x_fwd_rs_sel(rs_sel_b), .x_fwd_rt_sel(rt_sel_b), .x_valid(xv_b)
`ifdef HAZARD_STATS_EN
        , .stall_count(stc_b), .flush_count(flc_b), .bypass_count(byc_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One decode cycle: drive, check combinational stall, push expected X contents, compare after the edge.
    task automatic step(input string tag, input bit b, input bit rst, input bit v,
                        input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                        input logic [4:0] dst, input bit wen, input bit ld, input bit fl,
                        input bit es, input bit exv, input logic [1:0] ers, input logic [1:0] ert);
        xexp_t e;
        reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_dst = dst; id_wen = wen; id_is_load = ld; flush = fl;
        @(negedge clock);
        check({tag, " stall"}, 32'(b ? stall_b : stall_a), 32'(es));
        sb_q.push_back('{xv: exv, rs: ers, rt: ert});
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check({tag, " x_valid"}, 32'(b ? xv_b : xv_a), 32'(e.xv));
        check({tag, " rs_sel"}, 32'(b ? rs_sel_b : rs_sel_a), 32'(e.rs));
        check({tag, " rt_sel"}, 32'(b ? rt_sel_b : rt_sel_a), 32'(e.rt));
    endtask

    task automatic bubbles(input string tag, input bit b, input int n);
        for (int i = 0; i < n; i++) step(tag, b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset state
        step("rst0", 0, 1, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0, 0);
        step("rst1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // add r3,r1,r2 ; sub r4,r3,r5
        step("mx_add", 0, 0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0);
        step("mx_sub", 0, 0, 1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0, 1, 2'd1, 0);
        bubbles("clr1", 0, 3);

        // add r3 ; nop ; or r6,r0,r3
        step("wx_add", 0, 0, 1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0);
        step("wx_nop", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("wx_or", 0, 0, 1, 5'd0, 5'd3, 1, 1, 5'd6, 1, 0, 0, 0, 1, 0, 2'd2);
        bubbles("clr2", 0, 3);

        // lw r7 ; add r8,r7,r7 (one stall cycle) ; add r9,r7,r0 sees retiring load
        step("lu_lw", 0, 0, 1, 5'd29, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1, 0, 0);
        step("lu_stall", 0, 0, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 1, 0, 0, 0);
        step("lu_go", 0, 0, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 0, 1, 2'd2, 2'd2);
        step("lu_ret", 0, 0, 1, 5'd7, 5'd0, 1, 1, 5'd9, 1, 0, 0, 0, 1, 0, 0);
        bubbles("clr3", 0, 3);

        // flush over a would-be stall; the load still moves to M
        step("fl_lw", 0, 0, 1, 5'd29, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1, 0, 0);
        step("fl_kill", 0, 0, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 1, 0, 0, 0, 0);
        step("fl_after", 0, 0, 1, 5'd7, 5'd0, 1, 1, 5'd10, 1, 0, 0, 0, 1, 2'd2, 0);
        bubbles("clr4", 0, 3);

        // r0, uses_* gating, youngest-match priority
        step("r0_addi", 0, 0, 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 1, 0, 0);
        step("r0_add", 0, 0, 1, 5'd0, 5'd0, 1, 1, 5'd2, 1, 0, 0, 0, 1, 0, 0);
        step("use_prod", 0, 0, 1, 5'd1, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0, 1, 0, 0);
        step("use_gate", 0, 0, 1, 5'd5, 5'd5, 0, 1, 5'd11, 1, 0, 0, 0, 1, 0, 2'd1);
        step("yng_old", 0, 0, 1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0);
        step("yng_new", 0, 0, 1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0, 0, 0, 1, 0, 0);
        step("yng_use", 0, 0, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 1, 2'd1, 2'd1);
        bubbles("clr5", 0, 3);

        // reset mid-stall
        step("rs_lw", 0, 0, 1, 5'd29, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0, 1, 0, 0);
        step("rs_stall", 0, 0, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 1, 0, 0, 0);
        step("rs_hit", 0, 1, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0, 0);
        step("rs_clean", 0, 0, 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 0, 1, 0, 0);

        // DEPTH=4, LOAD_STAGE=3 instance: two stall cycles, then sel=3
        step("d4_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("d4_lw", 1, 0, 1, 5'd29, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0, 1, 0, 0);
        step("d4_st1", 1, 0, 1, 5'd9, 5'd1, 1, 1, 5'd10, 1, 0, 0, 1, 0, 0, 0);
        step("d4_st2", 1, 0, 1, 5'd9, 5'd1, 1, 1, 5'd10, 1, 0, 0, 1, 0, 0, 0);
        step("d4_go", 1, 0, 1, 5'd9, 5'd1, 1, 1, 5'd10, 1, 0, 0, 0, 1, 2'd3, 0);
`ifdef HAZARD_STATS_EN
        check("d4 stall_count", stc_b, 32'd2);
        check("d4 bypass_count", byc_b, 32'd1);
        check("d4 flush_count", flc_b, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
